// File: rtl/sphere_bank_if.sv
// sphere_bank_if -- control/readback bundle for the sphere_bank physics store.
//   Frame_Tick    : pulse, start one update sweep over all slots
//   Hit/Hit_index : pulse + slot index, request respawn of that slot
//   Read_index    : slot whose state appears on Sphere_pos/Sphere_col next cycle
//   Sphere_pos    : 3 x 64-bit signed Q32.32 position of the read slot
//   Sphere_col    : 3 x 8-bit colour of the read slot
//   Busy          : sweep in progress
//   Update_done   : one-cycle pulse after the last slot is written
//   Frame_overrun : sticky, Frame_Tick arrived while not idle
// master = stimulus side, slave = sphere_bank.
interface sphere_bank_if #(
  parameter int N_SPHERES = 4
);
  localparam int IW = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;

  logic                 Frame_Tick;
  logic                 Hit;
  logic [IW-1:0]        Hit_index;
  logic [IW-1:0]        Read_index;
  logic [2:0][63:0]     Sphere_pos;
  logic [2:0][7:0]      Sphere_col;
  logic                 Busy;
  logic                 Update_done;
  logic                 Frame_overrun;

  modport master (
    output Frame_Tick, Hit, Hit_index, Read_index,
    input  Sphere_pos, Sphere_col, Busy, Update_done, Frame_overrun
  );

  modport slave (
    input  Frame_Tick, Hit, Hit_index, Read_index,
    output Sphere_pos, Sphere_col, Busy, Update_done, Frame_overrun
  );
endinterface

// File: rtl/sphere_bank.sv
// sphere_bank -- per-slot sphere state (pos/vel Q32.32, colour, pending respawn)
// with a sequential physics sweep, one slot per cycle, on each Frame_Tick.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-low
//   bus   : sphere_bank_if.slave (tick, hit, readback, status)
// Respawn velocities/colours come from a 64-bit Fibonacci LFSR that steps once
// per sweep cycle.
module sphere_bank #(
  parameter int          N_SPHERES = 4,
  parameter logic [63:0] GRAVITY   = 64'hFFFF_FFFE_0000_0000,
  parameter int          FLOOR     = 1440,
  parameter int          SPAWN_Y   = 304,
  parameter logic [63:0] SEED      = 64'h0123_4567_89AB_CDEF
) (
  input  logic          Clk,
  input  logic          Reset,
  sphere_bank_if.slave  bus
);
  localparam int                IW        = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
  localparam logic [63:0]       SPAWN_P   = 64'(SPAWN_Y) << 32;
  localparam logic [63:0]       FLOOR_Q   = 64'(FLOOR) << 32;
  localparam logic signed [63:0] FLOOR_NEG = -$signed(FLOOR_Q);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        k_q, k_d;
  logic [63:0]          lfsr_q, lfsr_d;
  logic [2:0][63:0]     pos_q [N_SPHERES];
  logic [2:0][63:0]     vel_q [N_SPHERES];
  logic [23:0]          col_q [N_SPHERES];
  logic [N_SPHERES-1:0] pend_q, pend_d;
  logic                 overrun_q, overrun_d;
  logic [2:0][63:0]     rd_pos_q, rd_pos_d;
  logic [23:0]          rd_col_q, rd_col_d;

  logic [2:0][63:0]     cur_pos, cur_vel, slot_pos, slot_vel;
  logic [23:0]          slot_col;
  logic                 hit_ok, hit_here, respawn;

  always_comb begin : fsm_next
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.Frame_Tick) begin
          state_d = SWEEP;
          k_d     = '0;
        end
      end
      SWEEP: begin
        if (k_q == IW'(N_SPHERES - 1)) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : slot_update
    cur_pos  = pos_q[k_q];
    cur_vel  = vel_q[k_q];
    hit_ok   = bus.Hit && (32'(bus.Hit_index) < N_SPHERES);
    // A hit on the slot being swept is consumed directly rather than via pending.
    hit_here = hit_ok && (bus.Hit_index == k_q) && (state_q == SWEEP);
    respawn  = pend_q[k_q] || hit_here || ($signed(cur_pos[2]) < FLOOR_NEG);

    slot_vel    = cur_vel;
    slot_vel[2] = cur_vel[2] + GRAVITY;
    for (int unsigned i = 0; i < 3; i++) begin
      slot_pos[i] = cur_pos[i] + slot_vel[i];
    end
    slot_col = col_q[k_q];

    if (respawn) begin
      slot_pos = {64'd0, SPAWN_P, 64'd0};
      slot_vel = {{16'd0, lfsr_q[63:48], 32'd0},
                  {{16{lfsr_q[0]}}, lfsr_q[47:32], 32'd0},
                  {{16{lfsr_q[1]}}, lfsr_q[31:16], 32'd0}};
      slot_col = lfsr_q[23:0];
    end
  end

  always_comb begin : misc_next
    pend_d = pend_q;
    if (state_q == SWEEP) pend_d[k_q] = 1'b0;
    if (hit_ok && !hit_here) pend_d[bus.Hit_index] = 1'b1;

    lfsr_d = lfsr_q;
    if (state_q == SWEEP) begin
      lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    end

    overrun_d = overrun_q | (bus.Frame_Tick && (state_q != IDLE));

    rd_pos_d = '0;
    rd_col_d = '0;
    if (32'(bus.Read_index) < N_SPHERES) begin
      rd_pos_d = pos_q[bus.Read_index];
      rd_col_d = col_q[bus.Read_index];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lfsr_q    <= SEED;
      pend_q    <= '0;
      overrun_q <= 1'b0;
      rd_pos_q  <= '0;
      rd_col_q  <= '0;
      for (int unsigned i = 0; i < N_SPHERES; i++) begin
        pos_q[i] <= {64'd0, SPAWN_P, 64'd0};
        vel_q[i] <= '0;
        col_q[i] <= '1;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lfsr_q    <= lfsr_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      rd_pos_q  <= rd_pos_d;
      rd_col_q  <= rd_col_d;
      if (state_q == SWEEP) begin
        pos_q[k_q] <= slot_pos;
        vel_q[k_q] <= slot_vel;
        col_q[k_q] <= slot_col;
      end
    end
  end

  assign bus.Sphere_pos    = rd_pos_q;
  assign bus.Sphere_col    = rd_col_q;
  assign bus.Busy          = (state_q == SWEEP);
  assign bus.Update_done   = (state_q == DONE);
  assign bus.Frame_overrun = overrun_q;
endmodule

// File: tb/tb_sphere_bank.sv
// tb_sphere_bank -- directed + random stimulus for sphere_bank against a
// frame/slot-level reference model; two single-slot instances probe the
// floor boundary from both sides and out-of-range readback.
module tb_sphere_bank;
  localparam int          N    = 4;
  localparam longint      ONE  = 64'sh1_0000_0000;
  localparam longint      GRAV = -64'sd2 * ONE;
  localparam longint      LIM  = 64'sd1440 * ONE;
  localparam longint      SPY  = 64'sd304 * ONE;
  localparam logic [63:0] SEED = 64'h0123456789ABCDEF;
  localparam logic [63:0] SP   = 64'h0000013000000000;
  localparam longint      GR_R = -64'sd8589934593;

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 Clk = ~Clk;

  sphere_bank_if #(.N_SPHERES(4)) bi ();
  sphere_bank_if #(.N_SPHERES(1)) be ();
  sphere_bank_if #(.N_SPHERES(1)) br ();

  sphere_bank #(.N_SPHERES(4)) dut (.Clk(Clk), .Reset(rst_n), .bus(bi.slave));
  sphere_bank #(.N_SPHERES(1), .FLOOR(2)) dut_e (.Clk(Clk), .Reset(rst_n), .bus(be.slave));
  sphere_bank #(.N_SPHERES(1), .FLOOR(2), .GRAVITY(64'hFFFFFFFDFFFFFFFF))
    dut_r (.Clk(Clk), .Reset(rst_n), .bus(br.slave));

  // reference model state
  longint           mpos [N][3];
  longint           mvel [N][3];
  logic [23:0]      mcol [N];
  bit               mpend [N];
  logic [63:0]      mr;
  int               mk;     // -1 idle, 0..N-1 slot being swept, N done
  bit               movr;
  logic [2:0][63:0] e_pos;
  logic [23:0]      e_col;
  int               nchk = 0;
  int               nfail = 0;

  function automatic logic [63:0] lfsr_next(input logic [63:0] r);
    return {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
  endfunction

  // 16-bit integer part, optionally negated by 2^16 when the sign source is set
  function automatic longint spawn_v(input logic [15:0] m, input bit s);
    return (longint'(m) - (s ? 64'sd65536 : 64'sd0)) * ONE;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mpos[i][2] = 0; mpos[i][1] = SPY; mpos[i][0] = 0;
      for (int c = 0; c < 3; c++) mvel[i][c] = 0;
      mcol[i]  = 24'hFFFFFF;
      mpend[i] = 1'b0;
    end
    mr = SEED; mk = -1; movr = 1'b0;
    e_pos = '0; e_col = '0;
  endtask

  task automatic update_slot(input int k, input bit forced);
    if (forced || mpend[k] || mpos[k][2] < -LIM) begin
      mpos[k][2] = 0; mpos[k][1] = SPY; mpos[k][0] = 0;
      mvel[k][2] = spawn_v(mr[63:48], 1'b0);
      mvel[k][1] = spawn_v(mr[47:32], mr[0]);
      mvel[k][0] = spawn_v(mr[31:16], mr[1]);
      mcol[k]    = mr[23:0];
      mpend[k]   = 1'b0;
    end else begin
      mvel[k][2] += GRAV;
      for (int c = 0; c < 3; c++) mpos[k][c] += mvel[k][c];
    end
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit hit,
                            input int hidx, input int ridx);
    bit same;
    if (!rst) begin
      model_reset();
      return;
    end
    e_pos = '0; e_col = '0;
    if (ridx < N) begin
      for (int c = 0; c < 3; c++) e_pos[c] = mpos[ridx][c];
      e_col = mcol[ridx];
    end
    same = 1'b0;
    if (hit && hidx < N) begin
      if (mk >= 0 && mk < N && hidx == mk) same = 1'b1;
      else mpend[hidx] = 1'b1;
    end
    if (tick && mk != -1) movr = 1'b1;
    if (mk >= 0 && mk < N) begin
      update_slot(mk, same);
      mr = lfsr_next(mr);
      mk++;
    end else if (mk == N) begin
      mk = -1;
    end else if (tick) begin
      mk = 0;
    end
  endtask

  task automatic cycle(input bit rst, input bit tick, input bit hit,
                       input int hidx, input int ridx);
    rst_n = rst;
    bi.Frame_Tick = tick; bi.Hit = hit;
    bi.Hit_index = 2'(hidx); bi.Read_index = 2'(ridx);
    @(posedge Clk);
    model_step(rst, tick, hit, hidx, ridx);
    #1;
    chk("pos",  bi.Sphere_pos, e_pos);
    chk("col",  bi.Sphere_col, e_col);
    chk("busy", bi.Busy, (mk >= 0 && mk < N));
    chk("done", bi.Update_done, (mk == N));
    chk("ovr",  bi.Frame_overrun, movr);
  endtask

  task automatic frame(input int ridx);
    cycle(1, 1, 0, 0, ridx);
    repeat (5) cycle(1, 0, 0, 0, ridx);
  endtask

  logic [63:0] r1;

  initial begin
    bi.Frame_Tick = 0; bi.Hit = 0; bi.Hit_index = 0; bi.Read_index = 0;
    be.Frame_Tick = 0; be.Hit = 0; be.Hit_index = 0; be.Read_index = 0;
    br.Frame_Tick = 0; br.Hit = 0; br.Hit_index = 0; br.Read_index = 0;
    model_reset();

    // reset state and first readback
    repeat (2) cycle(0, 0, 0, 0, 0);
    chk("rst_pos", bi.Sphere_pos, 192'd0);
    chk("rst_busy", bi.Busy, 1'b0);
    cycle(1, 0, 0, 0, 2);
    chk("rd2_pos", bi.Sphere_pos, {64'd0, SP, 64'd0});
    chk("rd2_col", bi.Sphere_col, 24'hFFFFFF);

    // floor boundary on single-slot instances (two ticks each)
    for (int t = 0; t < 2; t++) begin
      be.Frame_Tick = 1; br.Frame_Tick = 1;
      cycle(1, 0, 0, 0, 0);
      be.Frame_Tick = 0; br.Frame_Tick = 0;
      repeat (3) cycle(1, 0, 0, 0, 0);
    end
    r1 = lfsr_next(SEED);
    chk("flr_exact_pos", be.Sphere_pos, {64'hFFFFFFFA00000000, SP, 64'd0});
    chk("flr_exact_col", be.Sphere_col, 24'hFFFFFF);
    chk("flr_over_pos", br.Sphere_pos, {64'd0, SP, 64'd0});
    chk("flr_over_col", br.Sphere_col, r1[23:0]);
    be.Read_index = 1'b1;
    br.Frame_Tick = 1;
    cycle(1, 0, 0, 0, 0);
    br.Frame_Tick = 0;
    repeat (3) cycle(1, 0, 0, 0, 0);
    chk("oor_pos", be.Sphere_pos, 192'd0);
    chk("oor_col", be.Sphere_col, 24'd0);
    chk("flr_vel_pos", br.Sphere_pos,
        {64'(spawn_v(r1[63:48], 1'b0) + GR_R),
         64'(SPY + spawn_v(r1[47:32], r1[0])),
         64'(spawn_v(r1[31:16], r1[1]))});

    // single tick: latency and first update
    cycle(1, 1, 0, 0, 0);
    chk("busy_c1", bi.Busy, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      cycle(1, 0, 0, 0, 0);
      chk("busy_cn", bi.Busy, 1'b1);
    end
    cycle(1, 0, 0, 0, 0);
    chk("done_c5", bi.Update_done, 1'b1);
    chk("busy_c5", bi.Busy, 1'b0);
    cycle(1, 0, 0, 0, 0);
    chk("t1_pos2", bi.Sphere_pos[2], 64'hFFFFFFFE00000000);
    frame(0);
    frame(0);
    chk("t3_pos2", bi.Sphere_pos[2], 64'hFFFFFFF400000000);

    // hit slot 1 while idle, hit slot 3 in the cycle it is swept
    cycle(1, 0, 1, 1, 1);
    cycle(1, 1, 0, 0, 1);
    repeat (3) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 3, 3);
    cycle(1, 0, 0, 0, 1);
    chk("hit1_pos", bi.Sphere_pos, {64'd0, SP, 64'd0});
    cycle(1, 0, 0, 0, 3);
    chk("hit3_pos", bi.Sphere_pos, {64'd0, SP, 64'd0});
    frame(3);

    // tick during sweep, then reset mid-sweep
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);
    chk("ovr_sticky", bi.Frame_overrun, 1'b1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("mrst_pos", bi.Sphere_pos, 192'd0);
    chk("mrst_busy", bi.Busy, 1'b0);
    chk("mrst_ovr", bi.Frame_overrun, 1'b0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("mrst_rd", bi.Sphere_pos, {64'd0, SP, 64'd0});

    // random traffic; slots 2/3 never hit, so they fall through the floor
    for (int i = 0; i < 1500; i++) begin
      cycle(1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
